// File: rtl/dsp_ctrl_pkg.sv
// Shared constants and types for the I2S/DSP audio-path control sequencer.
package dsp_ctrl_pkg;

   localparam int CFG_W_DEF       = 4;
   localparam int RST_CYCLES_DEF  = 64;
   localparam int TIMEOUT_DEF     = 256;
   localparam int LOCK_PKTS_DEF   = 4;
   localparam int STABLE_PKTS_DEF = 8;
   localparam int MAX_RETRY_DEF   = 3;

   typedef enum logic [2:0] {
      RESET_HOLD = 3'd0,
      WAIT_LOCK  = 3'd1,
      RUN        = 3'd2,
      RECOVER    = 3'd3,
      FAULT      = 3'd4
   } state_e;

   localparam logic [2:0] ST_RESET_HOLD = RESET_HOLD;
   localparam logic [2:0] ST_WAIT_LOCK  = WAIT_LOCK;
   localparam logic [2:0] ST_RUN        = RUN;
   localparam logic [2:0] ST_RECOVER    = RECOVER;
   localparam logic [2:0] ST_FAULT      = FAULT;

   typedef struct packed {
      logic [CFG_W_DEF-1:0] freq;
      logic [CFG_W_DEF-1:0] scale;
   } cfg_t;

endpackage

// File: rtl/dsp_ctrl_seq_cfg_debounce.sv
// Switch synchronizers plus packet-based debounce; flags the strobe on which a
// candidate setting first becomes stable.
module cfg_debounce
   import dsp_ctrl_pkg::*;
#(
   parameter int CFG_W       = CFG_W_DEF,
   parameter int STABLE_PKTS = STABLE_PKTS_DEF
) (
   input  logic               clk_sys,
   input  logic               rst_b,
   input  logic [CFG_W-1:0]   freq_raw,
   input  logic [CFG_W-1:0]   scale_raw,
   input  logic               strobe_en,
   output logic [2*CFG_W-1:0] sync_cfg,
   output logic [2*CFG_W-1:0] cand_cfg,
   output logic               stable,
   output logic               apply_req
);

   localparam int CW = $clog2(STABLE_PKTS + 1);
   localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_PKTS);

   logic [2*CFG_W-1:0] meta;
   logic [CW-1:0]      stable_cnt;
   logic [CW-1:0]      cnt_nxt;
   logic               same;

   assign same   = (sync_cfg == cand_cfg);
   assign stable = (stable_cnt == STABLE_MAX);

   always_comb begin
      cnt_nxt = CW'(1);
      if (same) cnt_nxt = stable ? stable_cnt : stable_cnt + 1'b1;
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         meta       <= '0;
         sync_cfg   <= '0;
         cand_cfg   <= '0;
         stable_cnt <= '0;
         apply_req  <= 1'b0;
      end else begin
         meta      <= {freq_raw, scale_raw};
         sync_cfg  <= meta;
         apply_req <= 1'b0;
         if (strobe_en) begin
            cand_cfg   <= sync_cfg;
            stable_cnt <= cnt_nxt;
            // only the strobe that first reaches the threshold requests an apply
            apply_req  <= (cnt_nxt == STABLE_MAX) && !(stable && same);
         end
      end
   end

endmodule

// File: rtl/dsp_ctrl_seq.sv
// Bring-up, lock, config-apply and retry/fault sequencer for the I2S -> DSP -> I2S path.
//  state      | meaning
//  RESET_HOLD | path reset held low for RST_CYCLES
//  WAIT_LOCK  | path released, counting in-time packets toward lock
//  RUN        | locked; debounced settings applied on packet boundaries
//  RECOVER    | one-cycle retry bookkeeping after loss of lock or DSP error
//  FAULT      | retries exhausted; wait for user clear
module dsp_ctrl_seq
   import dsp_ctrl_pkg::*;
#(
   parameter int CFG_W       = CFG_W_DEF,
   parameter int RST_CYCLES  = RST_CYCLES_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF,
   parameter int LOCK_PKTS   = LOCK_PKTS_DEF,
   parameter int STABLE_PKTS = STABLE_PKTS_DEF,
   parameter int MAX_RETRY   = MAX_RETRY_DEF
) (
   input  logic             sclk_i,
   input  logic             rst_n_i,
   input  logic             pktStrobe_i,
   input  logic             dspError_i,
   input  logic [CFG_W-1:0] freqSetting_i,
   input  logic [CFG_W-1:0] scaleFactor_i,
   input  logic             clearFault_i,
   output logic [CFG_W-1:0] freqSetting_o,
   output logic [CFG_W-1:0] scaleFactor_o,
   output logic             cfgUpdate_o,
   output logic             rstI2S_n_o,
   output logic             running_o,
   output logic             errorLED_o,
   output logic [2:0]       state_o
);

   localparam int HW = $clog2(RST_CYCLES + 1);
   localparam int GW = $clog2(TIMEOUT + 1);
   localparam int LW = $clog2(LOCK_PKTS + 1);
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(TIMEOUT - 1);
   localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_PKTS - 1);
   localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

   logic [2:0]         state, state_nxt;
   logic [HW-1:0]      hold_cnt;
   logic [GW-1:0]      gap_cnt;
   logic [LW-1:0]      lock_cnt;
   logic [RW-1:0]      retry;
   logic [2*CFG_W-1:0] applied;
   logic [2*CFG_W-1:0] sync_cfg, cand_cfg;
   logic               stable, apply_req;
   logic               gap_expired, lock_done, dbnc_en, watching;

   cfg_debounce #(.CFG_W(CFG_W), .STABLE_PKTS(STABLE_PKTS)) u_debounce (
      .clk_sys   (sclk_i),
      .rst_b     (rst_n_i),
      .freq_raw  (freqSetting_i),
      .scale_raw (scaleFactor_i),
      .strobe_en (dbnc_en),
      .sync_cfg  (sync_cfg),
      .cand_cfg  (cand_cfg),
      .stable    (stable),
      .apply_req (apply_req)
   );

   assign watching    = (state == ST_WAIT_LOCK) || (state == ST_RUN);
   assign gap_expired = !pktStrobe_i && (gap_cnt == GAP_LAST);
   assign lock_done   = (state == ST_WAIT_LOCK) && pktStrobe_i && (lock_cnt == LOCK_LAST);
   // an error on a strobe cycle swallows the strobe entirely
   assign dbnc_en     = (state == ST_RUN) && pktStrobe_i && !dspError_i;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RESET_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = ST_WAIT_LOCK;
         ST_WAIT_LOCK:  if (lock_done) state_nxt = ST_RUN;
                        else if (gap_expired) state_nxt = ST_RECOVER;
         ST_RUN:        if (dspError_i || gap_expired) state_nxt = ST_RECOVER;
         ST_RECOVER:    state_nxt = (retry == RETRY_LAST) ? ST_FAULT : ST_RESET_HOLD;
         ST_FAULT:      if (clearFault_i) state_nxt = ST_RESET_HOLD;
         default:       state_nxt = ST_RESET_HOLD;
      endcase
   end

   always_ff @(posedge sclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= ST_RESET_HOLD;
         hold_cnt    <= '0;
         gap_cnt     <= '0;
         lock_cnt    <= '0;
         retry       <= '0;
         applied     <= '0;
         cfgUpdate_o <= 1'b0;
         rstI2S_n_o  <= 1'b0;
         running_o   <= 1'b0;
         errorLED_o  <= 1'b0;
      end else begin
         state       <= state_nxt;
         rstI2S_n_o  <= (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_RUN);
         running_o   <= (state_nxt == ST_RUN);
         errorLED_o  <= (state_nxt == ST_FAULT);
         cfgUpdate_o <= 1'b0;
         hold_cnt    <= ((state == ST_RESET_HOLD) && (state_nxt == ST_RESET_HOLD)) ?
                        hold_cnt + 1'b1 : '0;

         if (watching) begin
            gap_cnt <= pktStrobe_i ? '0 : gap_cnt + 1'b1;
            if ((state == ST_WAIT_LOCK) && pktStrobe_i) lock_cnt <= lock_cnt + 1'b1;
         end else begin
            gap_cnt  <= '0;
            lock_cnt <= '0;
         end

         if (state == ST_RECOVER) retry <= retry + 1'b1;
         else if (lock_done || ((state == ST_FAULT) && clearFault_i)) retry <= '0;

         if (lock_done) begin
            applied     <= stable ? cand_cfg : sync_cfg;
            cfgUpdate_o <= 1'b1;
         end else if ((state == ST_RUN) && !dspError_i && apply_req && (cand_cfg != applied)) begin
            applied     <= cand_cfg;
            cfgUpdate_o <= 1'b1;
         end
      end
   end

   assign freqSetting_o = applied[2*CFG_W-1:CFG_W];
   assign scaleFactor_o = applied[CFG_W-1:0];
   assign state_o       = state;

endmodule

// File: tb/tb_dsp_ctrl_seq.sv
// Scoreboard bench for dsp_ctrl_seq: a packet-level model predicts every config
// update; a negedge monitor pops and compares whenever cfgUpdate_o pulses.
module tb_dsp_ctrl_seq;
   import dsp_ctrl_pkg::*;

   localparam int E_RST    = 64;
   localparam int E_TMO    = 256;
   localparam int E_LOCK   = 4;
   localparam int E_STABLE = 8;
   localparam int PH_IDLE = 0, PH_LOCK = 1, PH_RUN = 2;

   logic       sclk = 1'b0, rst_n = 1'b0, strobe = 1'b0, dsp_err = 1'b0, clear_fault = 1'b0;
   logic [3:0] freq_in = '0, scale_in = '0;
   logic [3:0] freq_out, scale_out;
   logic       cfg_upd, rst_i2s, running, err_led;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   cfg_t       exp_q[$];
   cfg_t       popped;
   logic [7:0] prev_out = '0;
   logic [7:0] m_cand, m_applied;
   int         m_cnt, phase, lock_n;

   always #5 sclk = ~sclk;

   dsp_ctrl_seq dut (
      .sclk_i        (sclk),
      .rst_n_i       (rst_n),
      .pktStrobe_i   (strobe),
      .dspError_i    (dsp_err),
      .freqSetting_i (freq_in),
      .scaleFactor_i (scale_in),
      .clearFault_i  (clear_fault),
      .freqSetting_o (freq_out),
      .scaleFactor_o (scale_out),
      .cfgUpdate_o   (cfg_upd),
      .rstI2S_n_o    (rst_i2s),
      .running_o     (running),
      .errorLED_o    (err_led),
      .state_o       (state)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // monitor: every update must be predicted; outputs must never move silently
   always @(negedge sclk) begin
      if (rst_n) begin
         checks++;
         if (cfg_upd) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_cfg_update: got %h, expected no update", {freq_out, scale_out});
            end else begin
               popped = exp_q.pop_front();
               if ({freq_out, scale_out} != popped) begin
                  errors++;
                  $display("FAIL cfg_value: got %h, expected %h", {freq_out, scale_out}, popped);
               end
            end
         end else if ({freq_out, scale_out} != prev_out) begin
            errors++;
            $display("FAIL silent_cfg_change: got %h, expected %h", {freq_out, scale_out}, prev_out);
         end
      end
      prev_out = {freq_out, scale_out};
   end

   task automatic model_reset();
      m_cand = '0; m_applied = '0; m_cnt = 0; phase = PH_IDLE; lock_n = 0;
   endtask

   task automatic model_strobe(input logic [7:0] v, input bit err);
      if (phase == PH_LOCK) begin
         lock_n++;
         if (lock_n == E_LOCK) begin
            m_applied = (m_cnt >= E_STABLE) ? m_cand : v;
            exp_q.push_back(m_applied);
            phase = PH_RUN;
         end
      end else if (phase == PH_RUN) begin
         if (err) phase = PH_IDLE;
         else if (v == m_cand) begin
            if (m_cnt < E_STABLE) begin
               m_cnt++;
               if (m_cnt == E_STABLE && m_cand != m_applied) begin
                  m_applied = m_cand;
                  exp_q.push_back(m_cand);
               end
            end
         end else begin
            m_cand = v;
            m_cnt  = 1;
         end
      end
   endtask

   // called just after a posedge; returns just after the edge that samples the strobe
   task automatic send_pkt(input logic [3:0] f, input logic [3:0] s, input int gap, input bit err);
      freq_in = f; scale_in = s;
      repeat (gap) @(posedge sclk);
      #1;
      strobe = 1'b1; dsp_err = err;
      model_strobe({f, s}, err);
      @(posedge sclk); #1;
      strobe = 1'b0; dsp_err = 1'b0;
   endtask

   task automatic cycles_until_rst_high(input int limit, output int n);
      n = 0;
      while (!rst_i2s && n < limit) begin
         @(posedge sclk); #1; n++;
      end
   endtask

   task automatic lock_up(input string name, input logic [3:0] f, input logic [3:0] s);
      int n;
      cycles_until_rst_high(200, n);
      check({name, "_rst_release"}, int'(rst_i2s), 1);
      phase = PH_LOCK; lock_n = 0;
      for (int i = 0; i < E_LOCK; i++) send_pkt(f, s, $urandom_range(40, 5), 1'b0);
      check({name, "_run_state"}, int'(state), 2);
      check({name, "_running"}, int'(running), 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int n, rec;
      logic [7:0] v;
      model_reset();
      freq_in = 4'd3; scale_in = 4'd5;
      repeat (3) @(posedge sclk);
      #1;
      check("reset_state", int'(state), 0);
      check("reset_rst_i2s", int'(rst_i2s), 0);
      check("reset_cfg", int'({freq_out, scale_out}), 0);
      check("reset_flags", int'({cfg_upd, running, err_led}), 0);

      // startup: path reset released on the 64th edge, RUN on the 4th packet
      rst_n = 1'b1;
      cycles_until_rst_high(200, n);
      check("startup_rst_cycles", n, E_RST);
      check("startup_wait_lock", int'(state), 1);
      phase = PH_LOCK; lock_n = 0;
      for (int i = 0; i < 3; i++) send_pkt(4'd3, 4'd5, 99, 1'b0);
      check("startup_not_locked", int'(state), 1);
      send_pkt(4'd3, 4'd5, 99, 1'b0);
      check("startup_run", int'(state), 2);
      check("startup_cfg", int'({freq_out, scale_out}), 8'h35);

      // debounce 3 -> 7 with exact apply timing
      for (int i = 0; i < int'($urandom_range(10, 2)); i++) send_pkt(4'd3, 4'd5, $urandom_range(30, 5), 1'b0);
      for (int i = 0; i < E_STABLE; i++) send_pkt(4'd7, 4'd5, $urandom_range(30, 5), 1'b0);
      check("debounce_before_apply", int'(freq_out), 3);
      @(posedge sclk); #1;
      check("debounce_apply_freq", int'(freq_out), 7);
      check("debounce_apply_pulse", int'(cfg_upd), 1);
      @(posedge sclk); #1;
      check("debounce_pulse_width", int'(cfg_upd), 0);

      // glitch: short excursion then back to the applied value
      for (int i = 0; i < 3; i++) send_pkt(4'd9, 4'd5, $urandom_range(30, 5), 1'b0);
      for (int i = 0; i < 10; i++) send_pkt(4'd7, 4'd5, $urandom_range(30, 5), 1'b0);
      check("glitch_held", int'({freq_out, scale_out}), 8'h75);

      // random settings held for random packet counts
      for (int seg = 0; seg < 8; seg++) begin
         v = 8'($urandom);
         for (int i = 0; i < int'($urandom_range(12, 1)); i++)
            send_pkt(v[7:4], v[3:0], $urandom_range(30, 5), 1'b0);
      end

      // packet timeout in RUN
      n = 0;
      while (state != 3'd3 && n < 1000) begin
         @(posedge sclk); #1; n++;
      end
      phase = PH_IDLE;
      check("timeout_gap", n, E_TMO);
      check("timeout_rst_low", int'(rst_i2s), 0);
      cycles_until_rst_high(200, n);
      check("recover_rst_cycles", n, E_RST + 1);
      lock_up("relock", freq_in, scale_in);

      // error coincident with the strobe that would complete debounce
      v = m_cand ^ 8'h5A;
      if (v == m_applied) v = m_cand ^ 8'hA5;
      for (int i = 0; i < E_STABLE - 1; i++) send_pkt(v[7:4], v[3:0], $urandom_range(30, 5), 1'b0);
      send_pkt(v[7:4], v[3:0], $urandom_range(30, 5), 1'b1);
      check("simul_recover", int'(state), 3);
      check("simul_cfg_held", int'({freq_out, scale_out}), int'(m_applied));
      lock_up("simul_relock", v[7:4], v[3:0]);

      // persistent failures: three attempts end in FAULT
      dsp_err = 1'b1; phase = PH_IDLE;
      rec = 0; n = 0;
      while (state != 3'd4 && n < 3000) begin
         @(posedge sclk); #1; n++;
         if (state == 3'd3) rec++;
      end
      check("fault_attempts", rec, 3);
      check("fault_state", int'(state), 4);
      check("fault_led_rst_run", int'({err_led, rst_i2s, running}), 3'b100);
      repeat (10) @(posedge sclk);
      #1;
      check("fault_sticky", int'(state), 4);
      dsp_err = 1'b0;
      clear_fault = 1'b1;
      @(posedge sclk); #1;
      clear_fault = 1'b0;
      check("clear_state", int'(state), 0);
      check("clear_led", int'(err_led), 0);
      lock_up("post_fault", 4'd2, 4'd11);

      // mid-operation reset returns everything to zero
      for (int i = 0; i < 3; i++) send_pkt(4'd2, 4'd11, $urandom_range(30, 5), 1'b0);
      check("pending_before_reset", exp_q.size(), 0);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("midreset_state", int'(state), 0);
      check("midreset_cfg", int'({freq_out, scale_out}), int'(m_applied));
      check("midreset_flags", int'({rst_i2s, running, err_led, cfg_upd}), 0);
      repeat (2) @(posedge sclk);
      #1;
      rst_n = 1'b1;
      lock_up("after_reset", 4'd6, 4'd1);
      repeat (3) @(posedge sclk);
      #1;
      check("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dsp_ctrl_seq.md
Name: dsp_ctrl_seq

Overview:
Control sequencer for the I2S receive, DSP and I2S transmit audio path.
- Brings the path up by holding the I2S/DSP reset, then waits for receive-packet lock.
- Debounces the user frequency/scale switch settings and applies them only on packet boundaries.
- Watches for packet loss or a DSP error, retries via a reset pulse, and latches a fault LED after repeated failures.
- Sits beside the DSP and drives its config inputs and the path reset.

Parameters:
CFG_W, 4, width of each setting field (freqSetting, scaleFactor)
RST_CYCLES, 64, sclk_i cycles rstI2S_n_o is held low per reset attempt
TIMEOUT, 256, max sclk_i cycles allowed between pktStrobe_i pulses
LOCK_PKTS, 4, consecutive in-time packets required to declare lock
STABLE_PKTS, 8, consecutive identical switch samples required to apply a setting
MAX_RETRY, 3, failed attempts before FAULT

Ports:
sclk_i  in  1  bit clock, sole clock
rst_n_i  in  1  asynchronous active-low reset
pktStrobe_i  in  1  one-cycle pulse per received packet (synchronous to sclk_i)
dspError_i  in  1  DSP error level
freqSetting_i  in  CFG_W  raw switch input (asynchronous)
scaleFactor_i  in  CFG_W  raw switch input (asynchronous)
clearFault_i  in  1  user fault clear (synchronous level)
freqSetting_o  out  CFG_W  applied frequency setting
scaleFactor_o  out  CFG_W  applied scale factor
cfgUpdate_o  out  1  one-cycle pulse when the applied config changes
rstI2S_n_o  out  1  active-low reset to I2S/DSP path
running_o  out  1  high in RUN
errorLED_o  out  1  high in FAULT
state_o  out  3  current state encoding

Behaviour:
- One clock, sclk_i; reset rst_n_i is asynchronous, active-low. All outputs are registered.
- Reset values: state RESET_HOLD; rstI2S_n_o=0; freqSetting_o=0; scaleFactor_o=0; cfgUpdate_o=0; running_o=0; errorLED_o=0; retry=0; all counters 0.
- Switch inputs pass through 2-flop synchronizers (2-cycle latency) before any use.
- States (state_o): RESET_HOLD=0, WAIT_LOCK=1, RUN=2, RECOVER=3, FAULT=4.
- RESET_HOLD:
  - rstI2S_n_o=0. Counter runs 0..RST_CYCLES-1.
  - At terminal count, next state WAIT_LOCK, and rstI2S_n_o=1 from the same edge.
  - pktStrobe_i and dspError_i are ignored.
- WAIT_LOCK:
  - Gap counter clears on each strobe and otherwise increments.
  - Gap reaching TIMEOUT: go to RECOVER.
  - Each strobe increments lockCnt.
  - Strobe that makes lockCnt==LOCK_PKTS: go to RUN. Load applied config from the current stable candidate (or the synchronized inputs if none is stable), pulse cfgUpdate_o, clear retry.
  - dspError_i is ignored.
- RUN:
  - running_o=1. Gap watchdog runs as in WAIT_LOCK; timeout goes to RECOVER.
  - dspError_i=1 goes to RECOVER; error has priority over a simultaneous strobe, and no config apply occurs on that cycle.
  - Debounce, on each strobe:
    - Synchronized {freq,scale} equals candidate: stableCnt increments, saturating at STABLE_PKTS.
    - Otherwise: candidate is replaced and stableCnt=1.
  - Apply: when stableCnt first reaches STABLE_PKTS and candidate != applied, outputs update on the next edge with cfgUpdate_o=1 for exactly that cycle.
  - No re-apply while the candidate is unchanged.
- RECOVER (1 cycle):
  - retry increments and rstI2S_n_o=0.
  - If retry after increment == MAX_RETRY: go to FAULT. Else go to RESET_HOLD.
  - lockCnt and the gap counter are cleared.
  - Applied config outputs hold their last value.
- FAULT:
  - errorLED_o=1, rstI2S_n_o=0, running_o=0.
  - clearFault_i=1: go to RESET_HOLD, retry=0, errorLED_o=0 next cycle.
  - clearFault_i is ignored in all other states.
- Reset asserted mid-operation: immediate return to reset values; applied config returns to 0.
- The debounce candidate and stableCnt persist across RECOVER. They clear only on rst_n_i.

Decomposition:
- Package dsp_ctrl_pkg: state enum (3-bit, encodings above), default parameter constants, and a cfg_t struct {freq, scale}.
- One sub-module: cfg_debounce. It holds the synchronizers, candidate, stableCnt and apply-request logic, and is parameterized by CFG_W and STABLE_PKTS.

Test Plan:
- Startup: release reset, strobes every 100 cycles -> rstI2S_n_o rises at cycle 64; RUN after the 4th strobe; cfgUpdate_o pulses once with switch values (freq=3, scale=5).
- Debounce: in RUN change freq 3->7 and hold -> freqSetting_o=7 one cycle after the 8th matching strobe; exactly one cfgUpdate_o pulse.
- Glitch: freq=9 for 3 strobes, then back to 7 -> no output change, no cfgUpdate_o.
- Timeout: in RUN stop strobes -> RECOVER at gap 256; rstI2S_n_o low 64 cycles; retry=1; resumed strobes return the block to RUN with retry=0.
- Fault: dspError_i held high across attempts -> 3rd RECOVER enters FAULT, errorLED_o=1; clearFault_i pulse -> RESET_HOLD, errorLED_o=0.
- Simultaneous: dspError_i and pktStrobe_i on the cycle that would complete debounce -> RECOVER, outputs unchanged, no cfgUpdate_o.
